// File: rtl/axi_memif_master_pkg.sv
// Shared definitions for the mi-to-AXI4-Lite master bridge: response codes, protection default,
// FSM state encoding and the response-status helper.
package axi_memif_master_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRESP,
      ST_RADDR,
      ST_RDATA
   } state_e;

   // Any response other than OKAY is reported as an error, EXOKAY included.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_memif_master_if.sv
// Bundles the mi_* request side and the AXI4-Lite master channels of the bridge.
// The master modport is the bridge's view; slave is the view of whatever surrounds it.
interface axi_memif_master_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;

   logic          mi_access;
   logic          mi_write;
   logic [AW-1:0] mi_addr;
   logic [DW-1:0] mi_data_in;
   logic          mi_wait;
   logic          mi_wr_done;
   logic          mi_rd_valid;
   logic [DW-1:0] mi_data_out;
   logic          mi_err;

   logic [AW-1:0] m_axi_awaddr;
   logic [2:0]    m_axi_awprot;
   logic          m_axi_awvalid;
   logic          m_axi_awready;
   logic [DW-1:0] m_axi_wdata;
   logic [SW-1:0] m_axi_wstrb;
   logic          m_axi_wvalid;
   logic          m_axi_wready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid;
   logic          m_axi_bready;
   logic [AW-1:0] m_axi_araddr;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rvalid;
   logic          m_axi_rready;

   modport master (
      input  mi_access, mi_write, mi_addr, mi_data_in,
      output mi_wait, mi_wr_done, mi_rd_valid, mi_data_out, mi_err,
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      output mi_access, mi_write, mi_addr, mi_data_in,
      input  mi_wait, mi_wr_done, mi_rd_valid, mi_data_out, mi_err,
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready
   );

endinterface

// File: rtl/axi_memif_master.sv
// Single-outstanding bridge from mi_* register strobes to an AXI4-Lite master port.
// Write address and data channels complete independently; completion is reported as a one-cycle pulse.
module axi_memif_master
   import axi_memif_master_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic               clk,
   input  logic               reset,
   axi_memif_master_if.master bus
);

   state_e        r_state;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_awvalid;
   logic          r_wvalid;
   logic          r_aw_done;
   logic          r_w_done;
   logic          r_bready;
   logic          r_arvalid;
   logic          r_rready;
   logic          r_wait;
   logic          r_wr_done;
   logic          r_rd_valid;
   logic          r_err;

   logic w_aw_fire;
   logic w_w_fire;
   logic w_aw_ok;
   logic w_w_ok;

   assign w_aw_fire = r_awvalid & bus.m_axi_awready;
   assign w_w_fire  = r_wvalid & bus.m_axi_wready;
   // A channel counts as finished if it completed earlier or completes this cycle.
   assign w_aw_ok   = r_aw_done | w_aw_fire;
   assign w_w_ok    = r_w_done | w_w_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_bready   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_wait     <= 1'b0;
         r_wr_done  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_wr_done  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.mi_access) begin
                  r_addr <= bus.mi_addr;
                  r_wait <= 1'b1;
                  if (bus.mi_write) begin
                     r_wdata   <= bus.mi_data_in;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= ST_WRITE;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RADDR;
                  end
               end
            end
            ST_WRITE: begin
               if (w_aw_fire) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_fire) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_ok && w_w_ok) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WRESP;
               end
            end
            ST_WRESP: begin
               if (bus.m_axi_bvalid) begin
                  r_bready  <= 1'b0;
                  r_wr_done <= 1'b1;
                  r_err     <= resp_is_err(bus.m_axi_bresp);
                  r_wait    <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_RADDR: begin
               if (bus.m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (bus.m_axi_rvalid) begin
                  r_rready   <= 1'b0;
                  r_rdata    <= bus.m_axi_rdata;
                  r_rd_valid <= 1'b1;
                  r_err      <= resp_is_err(bus.m_axi_rresp);
                  r_wait     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.mi_wait       = r_wait;
   assign bus.mi_wr_done    = r_wr_done;
   assign bus.mi_rd_valid   = r_rd_valid;
   assign bus.mi_data_out   = r_rdata;
   assign bus.mi_err        = r_err;

   // Address and write data come from the request latches, so they stay put while any valid is up.
   assign bus.m_axi_awaddr  = r_addr;
   assign bus.m_axi_awprot  = AXI_PROT_DEFAULT;
   assign bus.m_axi_awvalid = r_awvalid;
   assign bus.m_axi_wdata   = r_wdata;
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wvalid  = r_wvalid;
   assign bus.m_axi_bready  = r_bready;
   assign bus.m_axi_araddr  = r_addr;
   assign bus.m_axi_arprot  = AXI_PROT_DEFAULT;
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_rready  = r_rready;

   a_aw_hold: assert property (@(posedge clk) disable iff (reset)
      (r_awvalid && !bus.m_axi_awready) |=> (r_awvalid && $stable(r_addr)));
   a_w_hold: assert property (@(posedge clk) disable iff (reset)
      (r_wvalid && !bus.m_axi_wready) |=> (r_wvalid && $stable(r_wdata)));
   a_ar_hold: assert property (@(posedge clk) disable iff (reset)
      (r_arvalid && !bus.m_axi_arready) |=> (r_arvalid && $stable(r_addr)));
   a_err_with_pulse: assert property (@(posedge clk) disable iff (reset)
      r_err |-> (r_wr_done || r_rd_valid));

endmodule

// File: tb/tb_axi_memif_master.sv
// Scoreboard bench for axi_memif_master: a randomised AXI4-Lite slave model answers requests,
// while a word-addressed reference memory predicts every completion the bridge reports.
module tb_axi_memif_master;
   import axi_memif_master_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;

   axi_memif_master_if #(.AW(AW), .DW(DW)) bus ();

   axi_memif_master #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int unsigned a_dly;
      int unsigned w_dly;
      int unsigned r_dly;
      logic [1:0]  resp;
   } plan_t;

   typedef struct {
      bit          wr;
      logic [31:0] data;
      bit          err;
      longint      acc_cyc;
      bit          best;
   } exp_t;

   plan_t       plan_q[$];
   exp_t        exp_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] slv_mem[logic [31:0]];
   int          n_checks = 0;
   int          n_fail = 0;
   longint      cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Words never written read back as a fixed function of their address.
   function automatic logic [31:0] blank_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs();
      chk("reset_ctrl", 64'({bus.mi_wait, bus.mi_wr_done, bus.mi_rd_valid, bus.mi_err,
                             bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                             bus.m_axi_arvalid, bus.m_axi_rready}), 64'(0));
      chk("reset_data", {bus.mi_data_out, bus.m_axi_awaddr}, 64'(0));
      chk("reset_wdata", 64'(bus.m_axi_wdata), 64'(0));
   endtask

   // ---------------- AXI4-Lite slave model ----------------
   task automatic slave_write(input plan_t p);
      int unsigned aw_left = p.a_dly;
      int unsigned w_left  = p.w_dly;
      int unsigned b_left  = p.r_dly;
      int unsigned guard   = 0;
      bit          aw_ok = 0;
      bit          w_ok = 0;
      logic [31:0] aa = '0;
      logic [31:0] wd = '0;
      while (!(aw_ok && w_ok)) begin
         if (reset) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            return;
         end
         if (!aw_ok) begin
            chk("awvalid_held", 64'(bus.m_axi_awvalid), 64'(1));
            chk("awaddr", 64'(bus.m_axi_awaddr), 64'(p.addr));
            chk("awprot", 64'(bus.m_axi_awprot), 64'(0));
            if (aw_left == 0) begin
               bus.m_axi_awready = 1'b1;
               aa = bus.m_axi_awaddr;
            end else aw_left--;
         end else chk("awvalid_dropped", 64'(bus.m_axi_awvalid), 64'(0));
         if (!w_ok) begin
            chk("wvalid_held", 64'(bus.m_axi_wvalid), 64'(1));
            chk("wdata", 64'(bus.m_axi_wdata), 64'(p.data));
            chk("wstrb", 64'(bus.m_axi_wstrb), 64'(4'hF));
            if (w_left == 0) begin
               bus.m_axi_wready = 1'b1;
               wd = bus.m_axi_wdata;
            end else w_left--;
         end else chk("wvalid_dropped", 64'(bus.m_axi_wvalid), 64'(0));
         @(negedge clk);
         if (bus.m_axi_awready) begin aw_ok = 1; bus.m_axi_awready = 1'b0; end
         if (bus.m_axi_wready)  begin w_ok = 1;  bus.m_axi_wready  = 1'b0; end
         guard++;
         if (guard > 64) begin
            chk("write_handshake_timeout", 64'({aw_ok, w_ok}), 64'(2'b11));
            return;
         end
      end
      slv_mem[aa] = wd;
      chk("valids_low_in_wresp", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 64'(0));
      while (b_left > 0) begin
         if (reset) return;
         chk("bready_waiting", 64'(bus.m_axi_bready), 64'(1));
         @(negedge clk);
         b_left--;
      end
      if (reset) return;
      chk("bready_at_bvalid", 64'(bus.m_axi_bready), 64'(1));
      bus.m_axi_bvalid = 1'b1;
      bus.m_axi_bresp  = p.resp;
      @(negedge clk);
      bus.m_axi_bvalid = 1'b0;
      bus.m_axi_bresp  = 2'b00;
      chk("bready_dropped", 64'(bus.m_axi_bready), 64'(0));
   endtask

   task automatic slave_read(input plan_t p);
      int unsigned ar_left = p.a_dly;
      int unsigned r_left  = p.r_dly;
      int unsigned guard   = 0;
      logic [31:0] aa = '0;
      forever begin
         if (reset) begin bus.m_axi_arready = 1'b0; return; end
         chk("arvalid_held", 64'(bus.m_axi_arvalid), 64'(1));
         chk("araddr", 64'(bus.m_axi_araddr), 64'(p.addr));
         chk("arprot", 64'(bus.m_axi_arprot), 64'(0));
         if (ar_left == 0) begin
            bus.m_axi_arready = 1'b1;
            aa = bus.m_axi_araddr;
         end else ar_left--;
         @(negedge clk);
         if (bus.m_axi_arready) begin bus.m_axi_arready = 1'b0; break; end
         guard++;
         if (guard > 64) begin
            chk("read_addr_timeout", 64'(guard), 64'(0));
            return;
         end
      end
      chk("arvalid_dropped", 64'(bus.m_axi_arvalid), 64'(0));
      while (r_left > 0) begin
         if (reset) return;
         chk("rready_waiting", 64'(bus.m_axi_rready), 64'(1));
         @(negedge clk);
         r_left--;
      end
      if (reset) return;
      chk("rready_at_rvalid", 64'(bus.m_axi_rready), 64'(1));
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rresp  = p.resp;
      bus.m_axi_rdata  = slv_mem.exists(aa) ? slv_mem[aa] : blank_word(aa);
      @(negedge clk);
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rresp  = 2'b00;
      bus.m_axi_rdata  = $urandom;
      chk("rready_dropped", 64'(bus.m_axi_rready), 64'(0));
   endtask

   initial begin : slave
      plan_t p;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rdata   = '0;
      forever begin
         @(negedge clk);
         if (reset) continue;
         if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) begin
            if (plan_q.size() == 0) begin
               chk("spurious_axi_request",
                   64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}), 64'(0));
            end else begin
               p = plan_q.pop_front();
               chk("request_kind",
                   64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}),
                   p.wr ? 64'(3'b110) : 64'(3'b001));
               if (p.wr) slave_write(p);
               else      slave_read(p);
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      exp_t        e;
      logic [31:0] last_rd;
      last_rd = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            last_rd = '0;
            continue;
         end
         if (bus.mi_wr_done || bus.mi_rd_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 64'({bus.mi_wr_done, bus.mi_rd_valid}), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("done_kind", 64'({bus.mi_wr_done, bus.mi_rd_valid}),
                   e.wr ? 64'(2'b10) : 64'(2'b01));
               chk("mi_err", 64'(bus.mi_err), 64'(e.err));
               if (!e.wr) last_rd = e.data;
               chk(e.wr ? "data_out_held_on_write" : "rd_data",
                   64'(bus.mi_data_out), 64'(last_rd));
               if (e.best) chk("best_case_latency", 64'(cyc - e.acc_cyc), 64'(3));
            end
         end else begin
            chk("err_without_pulse", 64'(bus.mi_err), 64'(0));
            chk("data_out_held", 64'(bus.mi_data_out), 64'(last_rd));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int unsigned a_dly, input int unsigned w_dly,
                        input int unsigned r_dly, input logic [1:0] resp);
      plan_t       p;
      exp_t        e;
      int unsigned guard = 0;
      // Stray strobes while busy must be ignored by the bridge.
      while (bus.mi_wait) begin
         bus.mi_access  = ($urandom_range(0, 2) == 0);
         bus.mi_write   = 1'($urandom);
         bus.mi_addr    = $urandom;
         bus.mi_data_in = $urandom;
         guard++;
         if (guard > 200) begin
            chk("mi_wait_timeout", 64'(bus.mi_wait), 64'(0));
            bus.mi_access = 1'b0;
            return;
         end
         @(negedge clk);
      end
      p.wr = wr; p.addr = addr; p.data = data;
      p.a_dly = a_dly; p.w_dly = w_dly; p.r_dly = r_dly; p.resp = resp;
      plan_q.push_back(p);
      e.wr      = wr;
      e.err     = (resp != 2'b00);
      e.data    = wr ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : blank_word(addr));
      e.acc_cyc = cyc;
      e.best    = (a_dly == 0) && (w_dly == 0) && (r_dly == 0);
      exp_q.push_back(e);
      if (wr) ref_mem[addr] = data;
      bus.mi_access  = 1'b1;
      bus.mi_write   = wr;
      bus.mi_addr    = addr;
      bus.mi_data_in = data;
      @(negedge clk);
      bus.mi_access  = 1'b0;
   endtask

   initial begin : stim
      int unsigned g;
      logic [1:0]  rs;
      bus.mi_access  = 1'b0;
      bus.mi_write   = 1'b0;
      bus.mi_addr    = '0;
      bus.mi_data_in = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;

      issue(1'b1, 32'h0000_0F04, 32'hDEAD_BEEF, 0, 0, 0, RESP_OKAY);
      issue(1'b1, 32'h0000_0F08, 32'hCAFE_0001, 4, 0, 0, RESP_OKAY);
      issue(1'b1, 32'h0000_0F10, 32'h1234_5678, 0, 0, 0, RESP_OKAY);
      issue(1'b0, 32'h0000_0F10, 32'h0,         0, 0, 2, RESP_OKAY);
      issue(1'b1, 32'h0000_0F0C, 32'h0BAD_F00D, 0, 3, 1, RESP_OKAY);
      issue(1'b0, 32'h0000_0F04, 32'h0,         1, 0, 0, RESP_SLVERR);
      issue(1'b1, 32'h0000_0F14, 32'h5555_AAAA, 0, 0, 0, RESP_OKAY);
      issue(1'b0, 32'h0000_0F08, 32'h0,         0, 0, 0, RESP_OKAY);
      issue(1'b1, 32'h0000_0F18, 32'h7777_0000, 2, 2, 0, RESP_DECERR);
      issue(1'b0, 32'h0000_0F30, 32'h0,         0, 0, 1, RESP_DECERR);

      // Reset while the bridge waits in the write-response phase with bvalid low.
      issue(1'b1, 32'h0000_0F20, 32'h2020_2020, 0, 0, 10, RESP_OKAY);
      g = 0;
      while (!bus.m_axi_bready && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("bready_before_reset", 64'(bus.m_axi_bready), 64'(1));
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;

      issue(1'b0, 32'h0000_0F20, 32'h0, 0, 0, 0, RESP_OKAY);

      for (int i = 0; i < 160; i++) begin
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 3) == 0) begin
            issue(1'($urandom), 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4, $urandom,
                  0, 0, 0, rs);
         end else begin
            issue(1'($urandom), 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs);
         end
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      g = 0;
      while ((exp_q.size() != 0 || bus.mi_wait) && g < 100) begin
         @(negedge clk);
         g++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      chk("slave_plans_consumed", 64'(plan_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      repeat (50000) @(posedge clk);
      n_fail++;
      $display("FAIL watchdog: simulation still running at cycle %0d, limit 50000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
